// File: rtl/mac_operand_sequencer.sv
// Operand feeder for a signed MAC: FIFO-buffers operand pairs, issues VEC_LEN per dot product,
// captures the MAC result and clears the MAC. Optional stall counter: MAC_SEQ_STALL_CNT_EN.
module mac_operand_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned VEC_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          mac_a,
    output logic [DATA_W-1:0]          mac_b,
    output logic                       mac_valid_in,
    output logic                       mac_clear,
    input  logic [2*DATA_W-1:0]        mac_f,
    input  logic                       mac_valid_out,
    input  logic                       mac_overflow,
    output logic [2*DATA_W-1:0]        res_f,
    output logic                       res_overflow,
    output logic                       res_valid,
    output logic                       busy,
`ifdef MAC_SEQ_STALL_CNT_EN
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                stall_cnt
`else
    output logic [$clog2(DEPTH):0]     fifo_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = $clog2(VEC_LEN + 1);

    typedef enum logic [2:0] {StClear, StIdle, StFeed, StDrain, StCapture} state_e;

    state_e              state_q;
    logic [2*DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [NW-1:0]       issue_cnt_q, done_cnt_q;
    logic [2*DATA_W-1:0] head;
    logic                fifo_empty, push, pop;

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == StFeed) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    // Reset forces busy low even though the FSM parks in StClear.
    assign busy       = reset_n && (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StClear;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            mac_clear    <= 1'b1;
            res_f        <= '0;
            res_overflow <= 1'b0;
            res_valid    <= 1'b0;
            issue_cnt_q  <= '0;
            done_cnt_q   <= '0;
        end else begin
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            mac_clear    <= 1'b0;
            res_valid    <= 1'b0;
            case (state_q)
                StClear: begin
                    mac_clear   <= 1'b1;
                    issue_cnt_q <= '0;
                    done_cnt_q  <= '0;
                    state_q     <= StIdle;
                end
                StIdle: begin
                    if (!fifo_empty) state_q <= StFeed;
                end
                StFeed: begin
                    if (pop) begin
                        mac_a        <= head[2*DATA_W-1:DATA_W];
                        mac_b        <= head[DATA_W-1:0];
                        mac_valid_in <= 1'b1;
                        issue_cnt_q  <= issue_cnt_q + 1'b1;
                        if (issue_cnt_q == NW'(VEC_LEN - 1)) state_q <= StDrain;
                    end
                    // Early pairs complete while later ones are still being fed.
                    if (mac_valid_out) done_cnt_q <= done_cnt_q + 1'b1;
                end
                StDrain: begin
                    if (mac_valid_out) begin
                        done_cnt_q <= done_cnt_q + 1'b1;
                        if (done_cnt_q == NW'(VEC_LEN - 1)) state_q <= StCapture;
                    end
                end
                StCapture: begin
                    res_f        <= mac_f;
                    res_overflow <= mac_overflow;
                    res_valid    <= 1'b1;
                    state_q      <= StClear;
                end
                default: state_q <= StClear;
            endcase
        end
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((state_q == StFeed) && fifo_empty && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: behavioural MAC model, table-driven vectors and a
// result scoreboard, plus hand sequences for backpressure, reset and stall counting.
module tb_mac_operand_sequencer;

    localparam int DW = 8;
    localparam int VL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] mac_a, mac_b;
    logic          mac_valid_in, mac_clear;
    logic [15:0]   mac_f;
    logic          mac_valid_out, mac_overflow;
    logic [15:0]   res_f;
    logic          res_overflow, res_valid, busy;
    logic [2:0]    fifo_count;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    mac_operand_sequencer #(.DATA_W(DW), .DEPTH(4), .VEC_LEN(VL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_clear     (mac_clear),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .mac_overflow  (mac_overflow),
        .res_f         (res_f),
        .res_overflow  (res_overflow),
        .res_valid     (res_valid),
        .busy          (busy),
`ifdef MAC_SEQ_STALL_CNT_EN
        .fifo_count    (fifo_count),
        .stall_cnt     (stall_cnt)
`else
        .fifo_count    (fifo_count)
`endif
    );

    // MAC model: product registered on valid_in, accumulated next edge (f/valid_out at k+2),
    // wrapping 16-bit sum with sticky overflow. 'hold' defers valid_out pulses.
    logic               hold = 1'b0;
    logic signed [15:0] prod_c;
    logic [15:0]        prod_q, f_q;
    logic               v1_q, ovf_q, vo_q;
    logic [16:0]        sum_c;
    int                 pend_q;

    assign prod_c = $signed(mac_a) * $signed(mac_b);
    assign sum_c  = {f_q[15], f_q} + {prod_q[15], prod_q};
    assign mac_f         = f_q;
    assign mac_overflow  = ovf_q;
    assign mac_valid_out = vo_q;

    always_ff @(posedge clk) begin
        if (mac_clear) begin
            prod_q <= '0; f_q <= '0; v1_q <= 1'b0; ovf_q <= 1'b0; vo_q <= 1'b0; pend_q <= 0;
        end else begin
            v1_q   <= mac_valid_in;
            prod_q <= prod_c;
            if (v1_q) begin
                f_q <= sum_c[15:0];
                if (sum_c[16] != sum_c[15]) ovf_q <= 1'b1;
            end
            if (hold) begin
                vo_q   <= 1'b0;
                pend_q <= pend_q + int'(v1_q);
            end else if (v1_q || pend_q != 0) begin
                vo_q   <= 1'b1;
                pend_q <= pend_q + int'(v1_q) - 1;
            end else begin
                vo_q <= 1'b0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] f;
        logic        ovf;
    } res_t;
    res_t exp_q[$];

    // Independent reference: wrapping signed 16-bit accumulate with sticky overflow.
    function automatic res_t dot_ref(input logic [7:0] a[4], input logic [7:0] b[4]);
        res_t r;
        int   acc, s;
        logic [15:0] s16;
        acc = 0;
        r.ovf = 1'b0;
        for (int i = 0; i < VL; i++) begin
            s = acc + int'($signed(a[i])) * int'($signed(b[i]));
            if (s > 32767 || s < -32768) r.ovf = 1'b1;
            s16 = 16'(s);
            acc = int'($signed(s16));
        end
        r.f = 16'(acc);
        return r;
    endfunction

    // Monitor: scoreboard compare on res_valid, issue count per vector, clear follow-up.
    int   vin_cnt = 0;
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            vin_cnt = 0;
            prev_rv = 1'b0;
        end else begin
            if (prev_rv) chk("clear_after_res", 32'(mac_clear), 32'd1);
            if (mac_valid_in) vin_cnt++;
            else chk("mac_ab_zero_idle", 32'({mac_a, mac_b}), 32'd0);
            if (res_valid) begin
                chk("res_single_pulse", 32'(prev_rv), 32'd0);
                chk("issues_per_vector", 32'(vin_cnt), 32'(VL));
                vin_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got res_f=0x%0h, expected no result", res_f);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("res_f", 32'(res_f), 32'(e.f));
                    chk("res_overflow", 32'(res_overflow), 32'(e.ovf));
                end
            end
            prev_rv = res_valid;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0, expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_timeout: got %0d pending, expected 0", exp_q.size());
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic [7:0]  a[4];
        logic [7:0]  b[4];
        int          gap;
        logic [15:0] f;
        logic        ovf;
    } vec_t;
    vec_t tbl[7];

    task automatic set_vec(input int i, input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3,
                           input int gap, input logic [15:0] f, input logic ovf);
        tbl[i].a[0] = 8'(a0); tbl[i].b[0] = 8'(b0);
        tbl[i].a[1] = 8'(a1); tbl[i].b[1] = 8'(b1);
        tbl[i].a[2] = 8'(a2); tbl[i].b[2] = 8'(b2);
        tbl[i].a[3] = 8'(a3); tbl[i].b[3] = 8'(b3);
        tbl[i].gap = gap;
        tbl[i].f   = f;
        tbl[i].ovf = ovf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pa[4], pb[4];
        res_t       r;
        int         n;

        set_vec(0,    1,   1,    2,   2,    3,   3,  4,  4, 0, 16'd30,   1'b0);
        set_vec(1,    1,   1,    2,   2,    3,   3,  4,  4, 2, 16'd30,   1'b0);
        set_vec(2, -128,-128, -128,-128,    0,   0,  0,  0, 0, 16'h8000, 1'b1);
        set_vec(3,    1,   1,    1,   1,    1,   1,  1,  1, 0, 16'd4,    1'b0);
        set_vec(4,  127, 127,  127, 127, -128, 127,  1, -1, 1, 16'h3E81, 1'b0);
        set_vec(5,  100, 100,  100, 100,  100, 100,100,100, 0, 16'h9C40, 1'b1);
        set_vec(6,   -1,   1,   -1,   1,   -1,   1, -1,  1, 3, 16'hFFFC, 1'b0);

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mac_clear", 32'(mac_clear), 32'd1);
        chk("rst_mac_valid_in", 32'(mac_valid_in), 32'd0);
        chk("rst_res", 32'({res_f, res_overflow, res_valid}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Table vectors; entries after the first run back to back across vector boundaries.
        for (int i = 0; i < 7; i++) begin
            r.f = tbl[i].f;
            r.ovf = tbl[i].ovf;
            exp_q.push_back(r);
            for (int j = 0; j < VL; j++) begin
                push(tbl[i].a[j], tbl[i].b[j]);
                repeat (tbl[i].gap) begin @(posedge clk); #1; end
            end
            if (i == 0) begin
                wait_res();
                chk("busy_after_vector", 32'(busy), 32'd0);
                chk("fifo_empty_after", 32'(fifo_count), 32'd0);
            end
        end
        wait_res();

        // Backpressure: consumer held in drain while the FIFO fills.
        hold = 1'b1;
        pa = '{8'd5, 8'd6, 8'd7, 8'd8};
        pb = '{8'd1, 8'd2, 8'd3, 8'd4};
        exp_q.push_back(dot_ref(pa, pb));
        for (int j = 0; j < VL; j++) push(pa[j], pb[j]);
        repeat (8) begin @(posedge clk); #1; end
        pa = '{8'hFD, 8'd10, 8'd2, 8'd0};
        pb = '{8'd4, 8'hF6, 8'd2, 8'd9};
        exp_q.push_back(dot_ref(pa, pb));
        for (int j = 0; j < VL; j++) push(pa[j], pb[j]);
        chk("full_fifo_count", 32'(fifo_count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        pa = '{8'd11, 8'hF9, 8'd1, 8'hFE};
        pb = '{8'd11, 8'd3, 8'd1, 8'hFE};
        exp_q.push_back(dot_ref(pa, pb));
        fork
            push(pa[0], pb[0]);
            begin
                repeat (5) begin @(posedge clk); #1; end
                chk("fifth_held_count", 32'(fifo_count), 32'd4);
                hold = 1'b0;
            end
        join
        for (int j = 1; j < VL; j++) push(pa[j], pb[j]);
        wait_res();

        // Reset in the middle of a vector: partial result and queued pair discarded.
        for (int j = 0; j < VL; j++) push(8'd9, 8'd9);
        n = 0;
        while (vin_cnt < 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("second_issue_seen", 32'(vin_cnt >= 2), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_mac_clear", 32'(mac_clear), 32'd1);
        chk("midrst_mac_out", 32'({mac_a, mac_b, mac_valid_in}), 32'd0);
        chk("midrst_res_f", 32'(res_f), 32'd0);
        chk("midrst_res_flags", 32'({res_overflow, res_valid, busy}), 32'd0);
        chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // (2,3)x4 with a three-cycle starvation after the first pair.
        r.f = 16'd24;
        r.ovf = 1'b0;
        exp_q.push_back(r);
        push(8'd2, 8'd3);
        n = 0;
        while (!mac_valid_in && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("first_issue_seen", 32'(mac_valid_in), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int j = 1; j < VL; j++) push(8'd2, 8'd3);
        wait_res();
`ifdef MAC_SEQ_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
